// File: rtl/gray_updown_counter_pkg.sv
// rtl/gray_updown_counter_pkg.sv - shared Gray helpers and action encoding for the up/down counter
package gray_updown_counter_pkg;

    localparam int GRAY_MAX_W = 32;

    typedef enum logic [1:0] {
        ACT_HOLD  = 2'd0,
        ACT_CLR   = 2'd1,
        ACT_LOAD  = 2'd2,
        ACT_COUNT = 2'd3
    } act_e;

    function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Each binary bit is the XOR of all Gray bits at and above it.
    function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
        logic [GRAY_MAX_W-1:0] b;
        b = '0;
        for (int i = 0; i < GRAY_MAX_W; i++) begin
            b[i] = ^(g >> i);
        end
        return b;
    endfunction

endpackage

// File: rtl/gray_to_bin.sv
// rtl/gray_to_bin.sv - combinational width-generic Gray to binary decoder
module gray_to_bin #(
    parameter int W = 4
) (
    input  logic [W-1:0] gray,
    output logic [W-1:0] bin
);

    always_comb begin
        bin = '0;
        for (int i = 0; i < W; i++) begin
            bin[i] = ^(gray >> i);
        end
    end

endmodule

// File: rtl/gray_updown_counter.sv
// rtl/gray_updown_counter.sv - modulo-MOD up/down counter with registered binary and Gray outputs
module gray_updown_counter
    import gray_updown_counter_pkg::*;
#(
    parameter int MOD       = 16,
    parameter int RESET_VAL = 0,
    localparam int W        = $clog2(MOD)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         load,
    input  logic         load_gray,
    input  logic [W-1:0] load_val,
    input  logic         en,
    input  logic         up,
    output logic [W-1:0] bin_out,
    output logic [W-1:0] gray_out,
    output logic         wrap,
    output logic         load_err,
    output logic         zero,
    output logic         at_max
);

    generate
        if (MOD < 2) begin : g_bad_mod
            $error("gray_updown_counter: MOD must be >= 2");
        end
        if (RESET_VAL < 0 || RESET_VAL >= MOD) begin : g_bad_reset_val
            $error("gray_updown_counter: RESET_VAL must be in 0..MOD-1");
        end
    endgenerate

    localparam logic [W-1:0] MAX_VAL  = W'(MOD - 1);
    localparam logic [W-1:0] RST_BIN  = W'(RESET_VAL);
    localparam logic [W-1:0] RST_GRAY = W'(bin2gray(GRAY_MAX_W'(RST_BIN)));

    logic [W-1:0] bin_r;
    logic [W-1:0] gray_r;
    logic         wrap_r;
    logic         load_err_r;

    logic [W-1:0] load_decoded;
    logic [W-1:0] load_bin;
    logic         load_ok;

    act_e         act;
    logic [W:0]   step;
    logic [W-1:0] bin_nxt;
    logic [W-1:0] gray_nxt;
    logic         wrap_nxt;
    logic         load_err_nxt;

    gray_to_bin #(
        .W (W)
    ) u_load_decode (
        .gray (load_val),
        .bin  (load_decoded)
    );

    assign load_bin = load_gray ? load_decoded : load_val;
    // Widened compare keeps the check meaningful even when MOD fills the width.
    assign load_ok  = ({1'b0, load_bin} <= {1'b0, MAX_VAL});

    always_comb begin
        act          = ACT_HOLD;
        step         = '0;
        bin_nxt      = bin_r;
        wrap_nxt     = 1'b0;
        load_err_nxt = 1'b0;

        if (clr) begin
            act = ACT_CLR;
        end else if (load) begin
            act = ACT_LOAD;
        end else if (en) begin
            act = ACT_COUNT;
        end

        case (act)
            ACT_CLR: begin
                bin_nxt = '0;
            end
            ACT_LOAD: begin
                if (load_ok) begin
                    bin_nxt = load_bin;
                end else begin
                    load_err_nxt = 1'b1;
                end
            end
            ACT_COUNT: begin
                if (up) begin
                    step = {1'b0, bin_r} + 1'b1;
                    if (bin_r == MAX_VAL) begin
                        bin_nxt  = '0;
                        wrap_nxt = 1'b1;
                    end else begin
                        bin_nxt = step[W-1:0];
                    end
                end else begin
                    // Borrow out of the extra bit marks the 0 -> MOD-1 wrap.
                    step = {1'b0, bin_r} - 1'b1;
                    if (step[W]) begin
                        bin_nxt  = MAX_VAL;
                        wrap_nxt = 1'b1;
                    end else begin
                        bin_nxt = step[W-1:0];
                    end
                end
            end
            default: begin
                bin_nxt = bin_r;
            end
        endcase

        gray_nxt = W'(bin2gray(GRAY_MAX_W'(bin_nxt)));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_r      <= RST_BIN;
            gray_r     <= RST_GRAY;
            wrap_r     <= 1'b0;
            load_err_r <= 1'b0;
        end else begin
            bin_r      <= bin_nxt;
            gray_r     <= gray_nxt;
            wrap_r     <= wrap_nxt;
            load_err_r <= load_err_nxt;
        end
    end

    assign bin_out  = bin_r;
    assign gray_out = gray_r;
    assign wrap     = wrap_r;
    assign load_err = load_err_r;
    assign zero     = (bin_r == '0);
    assign at_max   = (bin_r == MAX_VAL);

endmodule

// File: tb/tb_gray_updown_counter.sv
// tb/tb_gray_updown_counter.sv - self-checking bench for gray_updown_counter
module tb_gray_updown_counter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clr;
    logic       load;
    logic       load_gray;
    logic [3:0] load_val;
    logic       en;
    logic       up;

    logic [3:0] bo [3];
    logic [3:0] go [3];
    logic       wr [3];
    logic       le [3];
    logic       zr [3];
    logic       am [3];

    int vectors     = 0;
    int miscompares = 0;

    int         mod_of [3] = '{16, 10, 16};
    int         rst_of [3] = '{0, 0, 3};
    int         mcnt   [3];
    bit         mwrap  [3];
    bit         merr   [3];
    bit         mstep;
    logic [3:0] prev_g [3];

    always #5 clk = ~clk;

    gray_updown_counter #(.MOD(16), .RESET_VAL(0)) u_m16 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .load_gray(load_gray),
        .load_val(load_val), .en(en), .up(up), .bin_out(bo[0]), .gray_out(go[0]),
        .wrap(wr[0]), .load_err(le[0]), .zero(zr[0]), .at_max(am[0]));

    gray_updown_counter #(.MOD(10), .RESET_VAL(0)) u_m10 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .load_gray(load_gray),
        .load_val(load_val), .en(en), .up(up), .bin_out(bo[1]), .gray_out(go[1]),
        .wrap(wr[1]), .load_err(le[1]), .zero(zr[1]), .at_max(am[1]));

    gray_updown_counter #(.MOD(16), .RESET_VAL(3)) u_m16_r3 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .load_gray(load_gray),
        .load_val(load_val), .en(en), .up(up), .bin_out(bo[2]), .gray_out(go[2]),
        .wrap(wr[2]), .load_err(le[2]), .zero(zr[2]), .at_max(am[2]));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int gray_of(input int b);
        return b ^ (b >> 1);
    endfunction

    // Inverse by search over the code table rather than by bit recurrence.
    function automatic int bin_of_gray(input int g);
        for (int b = 0; b < 16; b++) begin
            if (gray_of(b) == g) return b;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            mcnt[i]  = rst_of[i];
            mwrap[i] = 1'b0;
            merr[i]  = 1'b0;
        end
        mstep = 1'b0;
    endtask

    task automatic model_edge();
        int v;
        mstep = en && !clr && !load;
        for (int i = 0; i < 3; i++) begin
            mwrap[i] = 1'b0;
            merr[i]  = 1'b0;
            if (clr) begin
                mcnt[i] = 0;
            end else if (load) begin
                v = load_gray ? bin_of_gray(int'(load_val)) : int'(load_val);
                if (v < mod_of[i]) mcnt[i] = v;
                else merr[i] = 1'b1;
            end else if (en) begin
                if (up) begin
                    mwrap[i] = (mcnt[i] == mod_of[i] - 1);
                    mcnt[i]  = (mcnt[i] + 1) % mod_of[i];
                end else begin
                    mwrap[i] = (mcnt[i] == 0);
                    mcnt[i]  = (mcnt[i] + mod_of[i] - 1) % mod_of[i];
                end
            end
        end
    endtask

    task automatic check_all();
        bit pow2;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("bin[%0d]", i), 32'(bo[i]), 32'(mcnt[i]));
            check($sformatf("gray[%0d]", i), 32'(go[i]), 32'(gray_of(mcnt[i])));
            check($sformatf("wrap[%0d]", i), 32'(wr[i]), 32'(mwrap[i]));
            check($sformatf("load_err[%0d]", i), 32'(le[i]), 32'(merr[i]));
            check($sformatf("zero[%0d]", i), 32'(zr[i]), 32'(mcnt[i] == 0));
            check($sformatf("at_max[%0d]", i), 32'(am[i]), 32'(mcnt[i] == mod_of[i] - 1));
            pow2 = ((mod_of[i] & (mod_of[i] - 1)) == 0);
            if (mstep && (!mwrap[i] || pow2)) begin
                check($sformatf("gray_step[%0d]", i), 32'($countones(go[i] ^ prev_g[i])), 32'd1);
            end
            prev_g[i] = go[i];
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic set_in(input logic c, input logic l, input logic lg,
                          input logic [3:0] lv, input logic e, input logic u);
        clr = c; load = l; load_gray = lg; load_val = lv; en = e; up = u;
    endtask

    initial begin
        rst_n = 1'b0;
        set_in(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        check_all();
        check("rst_bin_r3", 32'(bo[2]), 32'd3);
        check("rst_gray_r3", 32'(go[2]), 32'b0010);
        rst_n = 1'b1;

        set_in(1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
        for (int k = 1; k <= 17; k++) begin
            cycle();
            check("up16_bin", 32'(bo[0]), 32'(k % 16));
            check("up16_wrap", 32'(wr[0]), 32'(k == 16));
        end

        set_in(1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        cycle();
        set_in(1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
        cycle();
        check("m10_dn_wrap_bin", 32'(bo[1]), 32'd9);
        check("m10_dn_wrap", 32'(wr[1]), 32'd1);
        check("m10_dn_at_max", 32'(am[1]), 32'd1);
        check("m10_dn_gray", 32'(go[1]), 32'd13);
        for (int k = 8; k >= 0; k--) begin
            cycle();
            check("m10_dn_bin", 32'(bo[1]), 32'(k));
            check("m10_dn_nowrap", 32'(wr[1]), 32'd0);
        end

        set_in(1'b0, 1'b1, 1'b0, 4'd12, 1'b0, 1'b0);
        cycle();
        check("m10_load12_err", 32'(le[1]), 32'd1);
        check("m10_load12_held", 32'(bo[1]), 32'd0);
        set_in(1'b0, 1'b1, 1'b1, 4'b0111, 1'b0, 1'b0);
        cycle();
        check("m10_loadg_bin", 32'(bo[1]), 32'd5);
        check("m10_loadg_gray", 32'(go[1]), 32'b0111);
        check("m10_loadg_err", 32'(le[1]), 32'd0);

        set_in(1'b0, 1'b1, 1'b0, 4'd7, 1'b0, 1'b0);
        cycle();
        set_in(1'b1, 1'b1, 1'b0, 4'd7, 1'b1, 1'b1);
        cycle();
        check("clr_wins_bin", 32'(bo[0]), 32'd0);
        check("clr_wins_wrap", 32'(wr[0]), 32'd0);
        set_in(1'b0, 1'b1, 1'b0, 4'd7, 1'b1, 1'b1);
        cycle();
        check("load_wins_bin", 32'(bo[0]), 32'd7);

        set_in(1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
        repeat (3) cycle();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        check("midrst_bin_r3", 32'(bo[2]), 32'd3);
        check("midrst_gray_r3", 32'(go[2]), 32'b0010);
        @(negedge clk);
        rst_n = 1'b1;
        cycle();
        check("resume_bin_r3", 32'(bo[2]), 32'd4);

        for (int n = 0; n < 10000; n++) begin
            set_in(($urandom_range(0, 31) == 0), ($urandom_range(0, 15) == 0),
                   1'($urandom), 4'($urandom), ($urandom_range(0, 3) != 0), 1'($urandom));
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
